// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator sweep driver.
// Imported by the RTL and by the testbench.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CMP_WIDTH = 2;

    // Wide enough for any practical operand width; callers zero-extend.
    localparam int GW = 16;

    function automatic logic golden_gt(input logic [GW-1:0] a,
                                       input logic [GW-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/pair_counter.sv
// Nested operand counter: b is the inner digit, a the outer.
// last flags the final pair (both all ones).
module pair_counter
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (clear) begin
            a <= '0;
            b <= '0;
        end else if (advance) begin
            b <= b + WIDTH'(1);
            if (&b) begin
                a <= a + WIDTH'(1);
            end
        end
    end

    assign last = (&a) & (&b);

endmodule

// File: rtl/cmp_sweep_driver.sv
// Exhaustive a/b sweep of a magnitude comparator with on-the-fly
// checking against a > b; reports error count and first failure.
module cmp_sweep_driver
    import cmp_pkg::*;
#(
    parameter int WIDTH  = CMP_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               is_greater_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b
);

    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("cmp_sweep_driver: SETTLE must be at least 1");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          advance;
    logic          last;
    logic          mismatch;
    logic [EW-1:0] err_nxt;

    assign accept   = ((state == IDLE) || (state == DONE)) && start;
    assign advance  = (state == SAMPLE) && !last;
    assign mismatch = (state == SAMPLE) &&
                      (is_greater_in != golden_gt(GW'(a_out), GW'(b_out)));
    assign err_nxt  = err_count + EW'(mismatch);

    pair_counter #(
        .WIDTH   (WIDTH)
    ) u_pairs (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (advance),
        .a       (a_out),
        .b       (b_out),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= DRIVE;
                        cnt             <= RELOAD;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_a     <= '0;
                        first_err_b     <= '0;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    err_count <= err_nxt;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_a     <= a_out;
                        first_err_b     <= b_out;
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        state <= DRIVE;
                        cnt   <= RELOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Directed bench for cmp_sweep_driver with behavioural comparator
// models (ideal, stuck-at, inverted, two-cycle delayed).
module tb_cmp_sweep_driver;
    import cmp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] a1, b1, fea1, feb1;
    logic [1:0] a3, b3, fea3, feb3;
    logic       g1, g3;
    logic       busy1, done1, pass1, fev1;
    logic       busy3, done3, pass3, fev3;
    logic [4:0] err1, err3;
    logic       d1_1, d2_1, d1_3, d2_3;
    int         mode = 0;
    int         total = 0;
    int         bad = 0;
    int         cyc;
    int         bb;

    always #5 clk = ~clk;

    cmp_sweep_driver #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_out(a1), .b_out(b1), .is_greater_in(g1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1),
        .first_err_a(fea1), .first_err_b(feb1)
    );

    cmp_sweep_driver #(.WIDTH(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a_out(a3), .b_out(b3), .is_greater_in(g3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3),
        .first_err_a(fea3), .first_err_b(feb3)
    );

    // Comparator with two cycles of output latency.
    always_ff @(posedge clk) begin
        d1_1 <= (a1 > b1);
        d2_1 <= d1_1;
        d1_3 <= (a3 > b3);
        d2_3 <= d1_3;
    end

    always_comb begin
        g1 = 1'b0;
        g3 = 1'b0;
        case (mode)
            0: begin g1 = (a1 > b1);  g3 = (a3 > b3);  end
            1: begin g1 = 1'b0;       g3 = 1'b0;       end
            2: begin g1 = 1'b1;       g3 = 1'b1;       end
            3: begin g1 = !(a1 > b1); g3 = !(a3 > b3); end
            4: begin g1 = d2_1;       g3 = d2_3;       end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input bit sel);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts edges after the accept edge until done; tallies busy gaps.
    task automatic wait_done(input bit sel, input int budget,
                             input int pulse_at, output int cycles,
                             output int busy_bad);
        cycles = 0;
        busy_bad = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (pulse_at > 0) start1 = (cycles == pulse_at);
            if (sel ? done3 : done1) break;
            if ((sel ? busy3 : busy1) !== 1'b1) busy_bad++;
        end
        start1 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state1", {a1, b1, busy1, done1, pass1, err1,
                             fev1, fea1, feb1}, 0);
        chk("reset_state3", {a3, b3, busy3, done3, pass3, err3,
                             fev3, fea3, feb3}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ideal comparator
        mode = 0;
        start_sweep(0);
        chk("ideal_busy_after_accept", busy1, 1);
        wait_done(0, 200, 0, cyc, bb);
        chk("ideal_cycles", cyc, 32);
        chk("ideal_busy_gaps", bb, 0);
        chk("ideal_busy_low_in_done", busy1, 0);
        chk("ideal_err", err1, 0);
        chk("ideal_pass", pass1, 1);
        chk("ideal_fev", fev1, 0);
        chk("ideal_hold_ab", {a1, b1}, 4'hf);

        // stuck at 0
        mode = 1;
        start_sweep(0);
        wait_done(0, 200, 0, cyc, bb);
        chk("s0_cycles", cyc, 32);
        chk("s0_err", err1, 6);
        chk("s0_pass", pass1, 0);
        chk("s0_first", {fev1, fea1, feb1}, 5'b1_01_00);

        // stuck at 1
        mode = 2;
        start_sweep(0);
        wait_done(0, 200, 0, cyc, bb);
        chk("s1_err", err1, 10);
        chk("s1_first", {fev1, fea1, feb1}, 5'b1_00_00);

        // inverted
        mode = 3;
        start_sweep(0);
        wait_done(0, 200, 0, cyc, bb);
        chk("inv_err", err1, 16);
        chk("inv_first", {fev1, fea1, feb1}, 5'b1_00_00);
        chk("inv_pass", pass1, 0);

        // reset during pair (1,3)
        mode = 1;
        start_sweep(0);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (a1 == 2'd1 && b1 == 2'd3) break;
        end
        chk("rst_pair_reached", {a1, b1}, 4'b0111);
        chk("rst_pre_err", err1, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", {a1, b1, busy1, done1, pass1, err1,
                                fev1, fea1, feb1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        start_sweep(0);
        wait_done(0, 200, 0, cyc, bb);
        chk("rst_restart_cycles", cyc, 32);
        chk("rst_restart_pass", {pass1, err1}, 6'b1_00000);

        // start pulse mid-sweep is ignored
        start_sweep(0);
        wait_done(0, 200, 10, cyc, bb);
        chk("midpulse_cycles", cyc, 32);
        chk("midpulse_busy_gaps", bb, 0);

        // start held across done: back-to-back sweeps
        mode = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, 200, 0, cyc, bb);
        chk("b2b_first_cycles", cyc, 32);
        chk("b2b_first_err", err1, 6);
        mode = 0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_restart", {busy1, done1, err1, fev1}, 8'b1_0_00000_0);
        start1 = 1'b0;
        wait_done(0, 200, 0, cyc, bb);
        chk("b2b_second_cycles", cyc, 32);
        chk("b2b_second_pass", pass1, 1);

        // SETTLE=3 instance
        mode = 0;
        start_sweep(1);
        wait_done(1, 300, 0, cyc, bb);
        chk("s3_cycles", cyc, 64);
        chk("s3_busy_gaps", bb, 0);
        chk("s3_pass", {pass3, err3}, 6'b1_00000);

        // delayed comparator
        mode = 4;
        start_sweep(1);
        wait_done(1, 300, 0, cyc, bb);
        chk("delay_s3_err", err3, 0);
        chk("delay_s3_pass", pass3, 1);
        start_sweep(0);
        wait_done(0, 200, 0, cyc, bb);
        chk("delay_s1_has_err", (err1 != 0), 1);
        chk("delay_s1_pass", pass1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_driver.md
Name: cmp_sweep_driver

Overview:
Self-checking stimulus engine for the 2-bit magnitude comparator; it sits on the comparator's input side.
- Walks every (a, b) operand pair, drives the pair onto the comparator inputs and waits a settle time.
- Samples the returned isGreater flag and checks it against an internal golden a > b.
- Reports an error count, the first failing pair and an overall pass flag; used on-board and in simulation to qualify comparator variants.

Parameters:
WIDTH, 2, operand width in bits; the sweep covers 2^(2*WIDTH) pairs.
SETTLE, 1, cycles each pair is held before sampling; legal range ≥1 (0 is illegal, flagged by elaboration assertion).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin sweep; accepted only in IDLE or DONE.
a_out  output  WIDTH  operand a to comparator.
b_out  output  WIDTH  operand b to comparator.
is_greater_in  input  1  comparator result for the current a_out/b_out.
busy  output  1  high while sweeping (DRIVE, SAMPLE).
done  output  1  high in DONE until the next accepted start.
pass  output  1  done & (err_count == 0).
err_count  output  2*WIDTH+1  mismatches this sweep; saturation is impossible because the width holds 2^(2*WIDTH).
first_err_valid  output  1  at least one mismatch recorded.
first_err_a  output  WIDTH  a of first mismatch.
first_err_b  output  WIDTH  b of first mismatch.

Behaviour:
- Reset (async, immediate) clears everything: state=IDLE; a_out, b_out, busy, done, pass, err_count, first_err_* = 0. The same applies when reset asserts mid-sweep; no partial result is retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE with start=1: at the next edge the block enters DRIVE.
  - a_out=b_out=0, settle counter=SETTLE-1.
  - err_count, first_err_* and done are cleared.
- DRIVE: counter decrements each cycle; at 0 the block moves to SAMPLE. DRIVE lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - mismatch = is_greater_in != (a_out > b_out), unsigned compare.
  - On mismatch: err_count+1. If first_err_valid=0, capture a_out/b_out and set first_err_valid.
- End of SAMPLE:
  - Last pair (a_out=b_out=all ones): go to DONE.
  - Otherwise: b_out+1; on b_out wrap to 0, a_out+1. Reload the counter and return to DRIVE. Order is b inner, a outer.
- Timing: each pair takes SETTLE+1 cycles, so done rises (2^(2*WIDTH))*(SETTLE+1) cycles after the start-accept edge. Defaults give 32.
- a_out/b_out hold their last value (all ones) in DONE and 0 in IDLE. They change only at the SAMPLE→DRIVE edge and are stable throughout DRIVE and SAMPLE.
- start while busy is ignored. start held continuously in DONE restarts immediately, giving back-to-back sweeps.
- busy and done are never high together. pass is registered together with done.
- All outputs are registered; is_greater_in is used only in SAMPLE and is sampled combinationally into the error registers.

Decomposition:
- Shared package cmp_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE), 2-bit encoding;
  - CMP_WIDTH default constant = 2;
  - function golden_gt(a, b) shared with the testbench.
- One natural sub-module, pair_counter: nested WIDTH-bit a/b counter.
  - Inputs: clear, advance.
  - Outputs: a, b, last (both all ones).
  - Same asynchronous active-low reset.

Test Plan:
- Ideal comparator model (is_greater_in = a_out > b_out), defaults, start pulse → done at cycle 32; busy high cycles 1-32; err_count=0; pass=1; first_err_valid=0.
- is_greater_in stuck at 0 → err_count=6 (pairs with a>b), pass=0, first_err_a=1, first_err_b=0.
- is_greater_in stuck at 1 → err_count=10; first mismatch captured at a=0, b=0. Inverted model → err_count=16, first error at (0,0).
- Assert rst_n low during the 8th pair (a=1, b=3) → all outputs 0 asynchronously, state IDLE. Restart with ideal model → pass after 32 cycles with err_count=0.
- Pulse start mid-sweep → ignored; done timing unchanged. Hold start high across DONE → second sweep begins on the next edge, err_count cleared, second done 32 cycles later.
- SETTLE=3, ideal model → each pair held 3 cycles then sampled; done after 64 cycles. Model with 2-cycle output delay → err_count=0. Same model with SETTLE=1 → err_count>0.
